// File: rtl/spi_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reader
// Brief    : SPI mode-3 (CPOL=1, CPHA=1) controller that reads one WIDTH-bit
//            frame from a peripheral and presents it MSB-first as a parallel
//            word with a one-cycle done pulse. All timing is derived from
//            sampling_clk; sclk and cs_n are registered outputs.
//
// Ports    : sampling_clk  in   system clock, posedge
//            rst           in   asynchronous active-high reset
//            start         in   one-cycle frame request, ignored while busy
//            busy          out  high from the cycle after an accepted start
//                               through the end of the inter-frame gap
//            done          out  one-cycle pulse when data_out is updated
//            data_out      out  last captured frame, first bit at the MSB
//            cs_n          out  chip select, active low
//            sclk          out  serial clock, idles high
//            miso          in   serial data from the peripheral
//
// Options  : SPI_MISO_SYNC_EN - when defined, miso passes through a 2-flop
//            synchronizer (reset to 0) before sampling; CLK_DIV must then be
//            at least 6. Otherwise miso is sampled straight from the pin and
//            CLK_DIV must be at least 4.
//
// Revision : 1.0 - initial release
// ============================================================================
module spi_reader #(
    parameter int WIDTH    = 128,  // frame length in bits (>= 2)
    parameter int CLK_DIV  = 8,    // sampling_clk cycles per sclk half-period
    parameter int CS_SETUP = 8,    // cs_n low to first sclk falling edge
    parameter int CS_HOLD  = 8,    // cycles between last HIGH phase and cs_n high
    parameter int CS_GAP   = 8     // minimum cs_n high cycles between frames
) (
    input  logic             sampling_clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             cs_n,
    output logic             sclk,
    input  logic             miso
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_bit_w = $clog2(WIDTH + 1);

    // One shared cycle counter serves every timed phase, so it is sized for
    // the longest of them.
    localparam int c_max_a   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_max_b   = (CS_HOLD > CS_GAP)   ? CS_HOLD : CS_GAP;
    localparam int c_cnt_max = (c_max_a > c_max_b)  ? c_max_a : c_max_b;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(CS_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CS_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(CS_GAP - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_bit_w-1:0] c_width      = c_bit_w'(WIDTH);
    localparam logic [c_bit_w-1:0] c_bit_one    = c_bit_w'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]     r_shift;
    logic [WIDTH-1:0]     r_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cs_n;
    logic                 r_sclk;
    logic                 w_miso;

    // ------------------------------------------------------------------------
    // miso sampling path
    // ------------------------------------------------------------------------
`ifdef SPI_MISO_SYNC_EN
    // Two-flop synchronizer. Sampling still happens on the LOW->HIGH edge,
    // so the data-valid window seen by the shift register is two cycles
    // later than the pin; CLK_DIV >= 6 keeps that inside the LOW phase.
    logic [1:0] r_miso_sync;

    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            r_miso_sync <= 2'b00;
        end else begin
            r_miso_sync <= {r_miso_sync[0], miso};
        end
    end

    assign w_miso = r_miso_sync[1];
`else
    assign w_miso = miso;
`endif

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    // r_cnt counts cycles spent in the current phase and is cleared on every
    // phase change, which includes every sclk transition.
    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b1;
        end else begin
            // done is a single-cycle pulse; only HOLD's exit raises it.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    r_cs_n    <= 1'b1;
                    r_sclk    <= 1'b1;
                    if (start) begin
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (r_cnt == c_setup_last) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b0;
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_LOW: begin
                    // The peripheral shifted on the falling edge; by the end
                    // of the low half-period its data is settled, so capture
                    // on the same edge that raises sclk.
                    if (r_cnt == c_div_last) begin
                        r_cnt     <= '0;
                        r_sclk    <= 1'b1;
                        r_shift   <= {r_shift[WIDTH-2:0], w_miso};
                        r_bit_cnt <= r_bit_cnt + c_bit_one;
                        r_state   <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_HIGH: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt <= '0;
                        if (r_bit_cnt < c_width) begin
                            r_sclk  <= 1'b0;
                            r_state <= S_LOW;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b1;
                        r_data  <= r_shift;
                        r_done  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_GAP: begin
                    // busy stays high here so that a start arriving on the
                    // done cycle, or during the gap, is dropped.
                    if (r_cnt == c_gap_last) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign busy     = r_busy;
    assign done     = r_done;
    assign data_out = r_data;
    assign cs_n     = r_cs_n;
    assign sclk     = r_sclk;

endmodule
`default_nettype wire

// File: tb/tb_spi_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_reader
// Brief    : Self-checking bench for spi_reader. A timeline model predicts
//            every output from the number of cycles since the accepted start;
//            a peripheral model shifts the loaded word out MSB-first on sclk
//            falling edges. A second instance with a short CLK_DIV checks
//            capture at the minimum divider for the selected build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reader;

    localparam int W    = 128;
    localparam int DIV  = 8;
    localparam int SET  = 8;
    localparam int HLD  = 8;
    localparam int GAP  = 8;
    localparam int L    = SET + 2 * DIV * W + HLD;   // cs_n low cycles: 2064
`ifdef SPI_MISO_SYNC_EN
    localparam int FAST_DIV = 6;
`else
    localparam int FAST_DIV = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         start_f = 1'b0;
    logic         busy, done, cs_n, sclk;
    logic         miso = 1'b0;
    logic [W-1:0] data_out;
    logic         busy_f, done_f, cs_n_f, sclk_f;
    logic         miso_f = 1'b0;
    logic [W-1:0] data_out_f;

    always #5 clk = ~clk;

    spi_reader #(.WIDTH(W), .CLK_DIV(DIV), .CS_SETUP(SET), .CS_HOLD(HLD), .CS_GAP(GAP)) dut (
        .sampling_clk (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .miso         (miso)
    );

    spi_reader #(.WIDTH(W), .CLK_DIV(FAST_DIV), .CS_SETUP(SET), .CS_HOLD(HLD), .CS_GAP(GAP)) dut_fast (
        .sampling_clk (clk),
        .rst          (rst),
        .start        (start_f),
        .busy         (busy_f),
        .done         (done_f),
        .data_out     (data_out_f),
        .cs_n         (cs_n_f),
        .sclk         (sclk_f),
        .miso         (miso_f)
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Peripheral models: drive the next bit on each sclk falling edge
    // while selected; a cs_n rising edge restarts the word.
    // ------------------------------------------------------------------
    logic [W-1:0] periph_word = '0;
    logic [W-1:0] periph_word_f = '0;
    int p_idx = 0;
    int p_idx_f = 0;

    always @(negedge sclk or posedge cs_n) begin
        if (cs_n === 1'b1) p_idx = 0;
        else if (p_idx < W) begin
            miso = periph_word[W-1-p_idx];
            p_idx++;
        end
    end

    always @(negedge sclk_f or posedge cs_n_f) begin
        if (cs_n_f === 1'b1) p_idx_f = 0;
        else if (p_idx_f < W) begin
            miso_f = periph_word_f[W-1-p_idx_f];
            p_idx_f++;
        end
    end

    // ------------------------------------------------------------------
    // Timeline model: k counts cycles since the accepted start.
    //   cs_n low for k < L, done at k == L, busy until k == L + GAP,
    //   sclk toggles every DIV cycles starting low at k == SET.
    // ------------------------------------------------------------------
    bit           m_active = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_data   = '0;
        end else if (m_active) begin
            m_k++;
            if (m_k == L) m_data = m_word;
            if (m_k == L + GAP) m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_k      = 0;
            m_word   = periph_word;
        end
    end

    function automatic logic exp_sclk();
        if (m_active && m_k >= SET && m_k < SET + 2 * DIV * W)
            return (((m_k - SET) / DIV) % 2) == 1;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("busy",     busy,     m_active);
            chk("cs_n",     cs_n,     !(m_active && m_k < L));
            chk("sclk",     sclk,     exp_sclk());
            chk("done",     done,     m_active && m_k == L);
            chk("data_out", data_out, m_data);
        end
    end

    // ------------------------------------------------------------------
    // Event monitor (edge counts, cs_n high run length)
    // ------------------------------------------------------------------
    logic p_sclk = 1'b1;
    logic p_cs   = 1'b1;
    int n_fall = 0, n_rise = 0, n_done = 0, n_cslow = 0, n_csfall = 0;
    int hi_run = 0, last_gap = 0, n_done_f = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (p_sclk === 1'b1 && sclk === 1'b0) n_fall++;
            if (p_sclk === 1'b0 && sclk === 1'b1) n_rise++;
            if (done === 1'b1) n_done++;
            if (done_f === 1'b1) n_done_f++;
            if (cs_n === 1'b0) n_cslow++;
            if (cs_n === 1'b1) hi_run++;
            else if (p_cs === 1'b1) begin
                n_csfall++;
                last_gap = hi_run;
                hi_run   = 0;
            end
        end
        p_sclk = sclk;
        p_cs   = cs_n;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no done within %0d cycles, got 0 expected 1", nm, budget);
        end
    endtask

    task automatic fast_frame(input logic [W-1:0] word, input string nm);
        int  base = n_done_f;
        bit  found = 1'b0;
        periph_word_f = word;
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        for (int i = 0; i < L + 200; i++) begin
            @(negedge clk);
            if (done_f === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({nm, "_done_seen"}, found, 1'b1);
        chk({nm, "_data"}, data_out_f, word);
        repeat (GAP + 4) @(negedge clk);
        chk({nm, "_done_count"}, n_done_f - base, 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int b_fall, b_rise, b_done, b_cslow, b_csfall;
        logic [W-1:0] w;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        // Reset values and 20 idle cycles
        @(negedge clk);
        chk("reset_cs_n", cs_n, 1'b1);
        chk("reset_sclk", sclk, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_data", data_out, '0);
        repeat (20) @(negedge clk);

        // Single frame with extra start pulses that must be dropped
        periph_word = 128'h0123456789ABCDEF_FEDCBA9876543210;
        b_fall = n_fall; b_rise = n_rise; b_done = n_done;
        b_cslow = n_cslow; b_csfall = n_csfall;
        pulse_start();
        repeat (9) @(negedge clk);
        pulse_start();
        wait_done(L + 100, "frame1");
        start = 1'b1;                       // start on the done cycle
        @(negedge clk);
        start = 1'b0;
        repeat (GAP + 20) @(negedge clk);
        chk("frame1_falls",   n_fall - b_fall, 128);
        chk("frame1_rises",   n_rise - b_rise, 128);
        chk("frame1_cs_low",  n_cslow - b_cslow, 2064);
        chk("frame1_dones",   n_done - b_done, 1);
        chk("frame1_frames",  n_csfall - b_csfall, 1);
        chk("frame1_data",    data_out, 128'h0123456789ABCDEF_FEDCBA9876543210);

        // Back-to-back: all ones then all zeros, start held to restart ASAP
        periph_word = '1;
        pulse_start();
        wait_done(L + 100, "ones");
        chk("ones_data", data_out, {W{1'b1}});
        periph_word = '0;
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0) break;
        end
        start = 1'b0;
        chk("gap_min", last_gap >= GAP, 1'b1);
        wait_done(L + 100, "zeros");
        chk("zeros_data", data_out, '0);
        repeat (GAP + 4) @(negedge clk);

        // Reset after 40 rising sclk edges
        periph_word = {16{8'hA5}};
        b_rise = n_rise; b_done = n_done;
        pulse_start();
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            if (n_rise - b_rise >= 40) break;
        end
        chk("rst_reached_40", n_rise - b_rise >= 40, 1'b1);
        chk("rst_pre_cs_n", cs_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_cs_n", cs_n, 1'b1);
        chk("rst_async_sclk", sclk, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_done", n_done - b_done, 0);
        chk("rst_data_kept", data_out, '0);
        pulse_start();
        wait_done(L + 100, "a5");
        chk("a5_data", data_out, {16{8'hA5}});
        repeat (GAP + 4) @(negedge clk);

        // Randomized frames with random stray start pulses while busy
        for (int r = 0; r < 3; r++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            periph_word = w;
            repeat ($urandom_range(0, 15)) @(negedge clk);
            pulse_start();
            for (int i = 0; i < L + 100; i++) begin
                @(negedge clk);
                if (done === 1'b1) break;
                start = ($urandom_range(0, 63) == 0);
            end
            start = 1'b0;
            chk("rand_done_seen", done, 1'b1);
            chk("rand_data", data_out, w);
            repeat ($urandom_range(0, GAP + 6)) @(negedge clk);
        end
        repeat (GAP + 4) @(negedge clk);

        // Minimum divider instance
        fast_frame({(W/8){8'hAA}}, "fast_aa");
        fast_frame({$urandom, $urandom, $urandom, $urandom}, "fast_rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
